// File: rtl/walk_pattern_pkg.sv
// Types and pattern arithmetic shared by the walking-pattern sequencer.
// Latency: pure functions, no state.
// Backpressure: not applicable; callers decide when to advance.
package walk_pattern_pkg;

    // Functions work on a fixed 16-bit container; callers pass their real width.
    localparam int MAX_W = 16;

    typedef enum logic [1:0] {
        WALK1 = 2'd0,
        WALK0 = 2'd1,
        COUNT = 2'd2,
        RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ones in the low w bits.
    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        logic [MAX_W:0] m;
        m = (17'd1 << w) - 17'd1;
        return m[MAX_W-1:0];
    endfunction

    // Pattern presented on the first beat of a sequence.
    function automatic logic [MAX_W-1:0] first_pattern(input mode_e m, input int unsigned w);
        case (m)
            WALK0:   return width_mask(w) & ~16'd1;
            COUNT:   return '0;
            default: return 16'd1;
        endcase
    endfunction

    // Pattern following p; walk-zero rotates so the single zero moves up.
    function automatic logic [MAX_W-1:0] next_pattern(input mode_e m, input logic [MAX_W-1:0] p,
                                                      input int unsigned w);
        case (m)
            WALK0:   return ((p << 1) | (p >> (w - 1))) & width_mask(w);
            COUNT:   return (p + 16'd1) & width_mask(w);
            default: return (p << 1) & width_mask(w);
        endcase
    endfunction

    // True when p is the final beat: top bit selected for walks, all ones for count.
    function automatic logic is_last(input mode_e m, input logic [MAX_W-1:0] p,
                                     input int unsigned w);
        logic [MAX_W-1:0] top;
        top = 16'd1 << (w - 1);
        case (m)
            WALK0:   return p == (width_mask(w) & ~top);
            COUNT:   return p == width_mask(w);
            default: return p == top;
        endcase
    endfunction

endpackage

// File: rtl/walk_pattern_gen.sv
// Emits walk-one / walk-zero / binary-count pattern sequences, one per accepted beat, then pulses done.
// Latency: start sampled at edge N gives first pattern after N; done follows the last handshake by one edge.
// Backpressure: pat_out/pat_valid hold while pat_ready is low; stalls may last indefinitely.
module walk_pattern_gen
    import walk_pattern_pkg::*;
#(
    parameter int WIDTH = 8   // legal 2..16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] pat_out,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   beat_cnt
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   cnt_q, cnt_d;

    mode_e            start_mode;
    logic [MAX_W-1:0] first_w;
    logic [MAX_W-1:0] next_w;
    logic             last_w;

    // Reserved mode code behaves as walk-one so the latched mode is always meaningful.
    assign start_mode = (mode_e'(mode) == RSVD) ? WALK1 : mode_e'(mode);
    assign first_w    = first_pattern(start_mode, WIDTH);
    assign next_w     = next_pattern(mode_q, MAX_W'(pat_q), WIDTH);
    assign last_w     = is_last(mode_q, MAX_W'(pat_q), WIDTH);

    // Next-state and output computation; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pat_d   = pat_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = start_mode;
                    cnt_d   = '0;
                    pat_d   = first_w[WIDTH-1:0];
                    vld_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (vld_q && pat_ready) begin
                    cnt_d = cnt_q + (WIDTH+1)'(1);
                    if (last_w) begin
                        vld_d   = 1'b0;
                        pat_d   = '0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        pat_d = next_w[WIDTH-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= WALK1;
            pat_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pat_out   = pat_q;
    assign pat_valid = vld_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_walk_pattern_gen.sv
// Scoreboard bench for walk_pattern_gen: an 8-bit and a 4-bit instance.
// Stimulus pushes expected beats/done counts; negedge monitors pop and compare.
// Stall stability is checked whenever valid was high without ready.
module tb_walk_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, rdy8, vld8, busy8, done8;
    logic [1:0] mode8;
    logic [7:0] pat8;
    logic [8:0] cnt8;
    logic       start4, rdy4, vld4, busy4, done4;
    logic [1:0] mode4;
    logic [3:0] pat4;
    logic [4:0] cnt4;

    walk_pattern_gen #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8),
        .pat_out(pat8), .pat_valid(vld8), .pat_ready(rdy8),
        .busy(busy8), .done(done8), .beat_cnt(cnt8)
    );

    walk_pattern_gen #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4),
        .pat_out(pat4), .pat_valid(vld4), .pat_ready(rdy4),
        .busy(busy4), .done(done4), .beat_cnt(cnt4)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] q8[$];
    int         d8[$];
    logic [3:0] q4[$];
    int         d4[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic       stall_prev8 = 1'b0;
    logic [7:0] prev_pat8;
    logic [7:0] e8;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev8 = 1'b0;
        end else begin
            if (stall_prev8) begin
                chk("stall_hold_pat8", pat8, prev_pat8);
                chk("stall_hold_vld8", vld8, 1);
            end
            if (vld8 && rdy8) begin
                if (q8.size() == 0) chk("extra_beat8", pat8, -1);
                else begin
                    e8 = q8.pop_front();
                    chk("pat8", pat8, e8);
                end
            end
            if (done8) begin
                if (d8.size() == 0) chk("unexpected_done8", 1, 0);
                else chk("beat_cnt8", cnt8, d8.pop_front());
            end
            stall_prev8 = vld8 && !rdy8;
            prev_pat8   = pat8;
        end
    end

    logic [3:0] e4;
    always @(negedge clk) begin
        if (!rst) begin
            if (vld4 && rdy4) begin
                if (q4.size() == 0) chk("extra_beat4", pat4, -1);
                else begin
                    e4 = q4.pop_front();
                    chk("pat4", pat4, e4);
                end
            end
            if (done4) begin
                if (d4.size() == 0) chk("unexpected_done4", 1, 0);
                else chk("beat_cnt4", cnt4, d4.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done8(output int k);
        k = 0;
        while (!done8 && k < 200) begin
            tick();
            k++;
        end
        if (!done8) chk("timeout_done8", 0, 1);
    endtask

    task automatic wait_done4(output int k);
        k = 0;
        while (!done4 && k < 200) begin
            tick();
            k++;
        end
        if (!done4) chk("timeout_done4", 0, 1);
    endtask

    task automatic push_walk1_8();
        for (int i = 0; i < 8; i++) q8.push_back(8'(1 << i));
        d8.push_back(8);
    endtask

    task automatic push_walk0_8();
        for (int i = 0; i < 8; i++) q8.push_back(~8'(1 << i));
        d8.push_back(8);
    endtask

    int k;
    int cyc;

    initial begin
        rst = 1'b1;
        start8 = 1'b0; mode8 = 2'd0; rdy8 = 1'b1;
        start4 = 1'b0; mode4 = 2'd0; rdy4 = 1'b1;

        // Reset then idle: everything zero, valid never rises.
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_pat8", pat8, 0);
            chk("idle_vld8", vld8, 0);
            chk("idle_busy8", busy8, 0);
            chk("idle_done8", done8, 0);
            chk("idle_cnt8", cnt8, 0);
            chk("idle_vld4", vld4, 0);
        end

        // Walk-one, ready tied high: done after exactly 8 more edges.
        push_walk1_8();
        mode8 = 2'd0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("first_busy8", busy8, 1);
        wait_done8(k);
        chk("walk1_done_latency", k, 8);
        chk("walk1_done_pat", pat8, 0);
        tick();
        chk("walk1_busy_after", busy8, 0);
        chk("walk1_cnt_hold", cnt8, 8);

        // Walk-zero with ready cycling 1,0,0,1.
        push_walk0_8();
        mode8 = 2'd1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 200) begin
            rdy8 = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick();
            cyc++;
        end
        if (!done8) chk("timeout_walk0", 0, 1);
        rdy8 = 1'b1;
        tick();

        // Count mode on the 4-bit instance: 0..F, no wrap.
        for (int i = 0; i < 16; i++) q4.push_back(4'(i));
        d4.push_back(16);
        mode4 = 2'd2; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4(k);
        chk("count_done_latency", k, 16);
        chk("count_vld_at_done", vld4, 0);
        chk("count_pat_at_done", pat4, 0);
        tick();
        chk("count_busy_after", busy4, 0);

        // Starts in RUN and DONE ignored; reserved mode runs walk-one.
        push_walk1_8();
        push_walk0_8();
        mode8 = 2'd3; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        start8 = 1'b1; mode8 = 2'd1;
        tick();
        start8 = 1'b0; mode8 = 2'd2;
        wait_done8(k);
        start8 = 1'b1; mode8 = 2'd2;
        tick();
        chk("ignored_done_start_busy", busy8, 0);
        chk("ignored_done_start_vld", vld8, 0);
        mode8 = 2'd1;
        tick();
        start8 = 1'b0;
        chk("restart_vld", vld8, 1);
        chk("restart_pat", pat8, 8'hFE);
        wait_done8(k);
        tick();

        // Reset while beat 3 of walk-one is presented.
        q8.push_back(8'h01);
        q8.push_back(8'h02);
        mode8 = 2'd0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        chk("midrun_pat", pat8, 8'h04);
        chk("midrun_cnt", cnt8, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_vld", vld8, 0);
        chk("abort_busy", busy8, 0);
        chk("abort_pat", pat8, 0);
        chk("abort_cnt", cnt8, 0);
        chk("abort_done", done8, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", done8, 0);
        end

        chk("q8_drained", q8.size(), 0);
        chk("d8_drained", d8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        chk("d4_drained", d4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
